// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture readout path.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address and sample widths
//   rd_state_t              : readout FSM state encoding
//   wrap_inc()              : circular-buffer address increment (modulus -> 0)
package scope_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } rd_state_t;

    // Next address in a circular buffer whose highest valid address is modulus.
    function automatic logic [ADDR_W_DEF-1:0] wrap_inc(input logic [ADDR_W_DEF-1:0] addr,
                                                        input logic [ADDR_W_DEF-1:0] modulus);
        return (addr == modulus) ? '0 : addr + ADDR_W_DEF'(1);
    endfunction

endpackage

// File: rtl/capture_readout_if.sv
// Bundle of the readout control, RAM read and output stream signals.
//   control : start, trig_addr, pretrig, length, modulus -> busy, done
//   RAM     : ram_rd, ram_addr -> ram_rdata (one cycle latency)
//   stream  : out_data, out_valid, out_last <- out_ready
// slave is the readout engine's view, master is the host/RAM/consumer view.
interface capture_readout_if #(
    parameter int unsigned ADDR_W = scope_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = scope_pkg::DATA_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] pretrig;
    logic [ADDR_W-1:0] length;
    logic [ADDR_W-1:0] modulus;
    logic              busy;
    logic              done;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport slave (
        input  start, trig_addr, pretrig, length, modulus, ram_rdata, out_ready,
        output busy, done, ram_rd, ram_addr, out_data, out_valid, out_last
    );

    modport master (
        output start, trig_addr, pretrig, length, modulus, ram_rdata, out_ready,
        input  busy, done, ram_rd, ram_addr, out_data, out_valid, out_last
    );

endinterface

// File: rtl/readout_skid.sv
// Two-entry FIFO of {last, data} that catches RAM read data the consumer
// could not take yet.
//   clk, reset_n           : clock, async active-low reset (empties the FIFO)
//   push_i/push_last_i/... : write one entry
//   pop_i                  : drop the head entry
//   count_o                : occupancy 0..2
//   head_last_o/head_data_o: head entry (meaningful when count_o != 0)
module readout_skid import scope_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              push_last_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic              head_last_o,
    output logic [DATA_W-1:0] head_data_o
);

    logic [DATA_W:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign count_o                    = count_q;
    assign {head_last_o, head_data_o} = mem_q[rd_ptr_q];

endmodule

// File: rtl/capture_readout.sv
// Streams a window of samples out of the circular capture RAM.
// On start, the window begins pretrig samples (clamped to the buffer) before
// trig_addr and covers length samples, wrapping from modulus to 0.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : control (start/params, busy/done), RAM read port,
//                  valid/ready output stream with last marker
module capture_readout import scope_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    capture_readout_if.slave bus
);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] trig_q, trig_d, pre_q, pre_d, len_q, len_d, mod_q, mod_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rem_q, rem_d;
    logic              inflight_q, inflight_d, infl_last_q, infl_last_d;

    logic [1:0]        fifo_cnt;
    logic              fifo_last;
    logic [DATA_W-1:0] fifo_data;

    logic              head_valid, head_last, pop, fifo_pop, push, issue;
    logic [DATA_W-1:0] head_data;
    logic [2:0]        occ_w;
    logic [ADDR_W:0]   p_w, start_w;

    // The read returning this cycle is presented directly when the FIFO is
    // empty, so the first sample is visible in the cycle its data arrives.
    always_comb begin
        head_valid = (fifo_cnt != 2'd0) || inflight_q;
        if (fifo_cnt != 2'd0) begin
            head_data = fifo_data;
            head_last = fifo_last;
        end else begin
            head_data = bus.ram_rdata;
            head_last = infl_last_q;
        end
        pop      = head_valid && bus.out_ready;
        fifo_pop = pop && (fifo_cnt != 2'd0);
        push     = inflight_q && !(pop && (fifo_cnt == 2'd0));
        // Buffered plus in-flight after this cycle's pop must leave room.
        occ_w    = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
        issue    = (state_q == StRun) && (rem_q != '0) && (occ_w < 3'd2);
    end

    // Window start, computed one bit wider so the wrap case cannot overflow.
    always_comb begin
        p_w = (pre_q > mod_q) ? {1'b0, mod_q} : {1'b0, pre_q};
        if (p_w <= {1'b0, trig_q}) begin
            start_w = {1'b0, trig_q} - p_w;
        end else begin
            start_w = {1'b0, trig_q} + {1'b0, mod_q} + (ADDR_W + 1)'(1) - p_w;
        end
    end

    always_comb begin
        state_d     = state_q;
        trig_d      = trig_q;
        pre_d       = pre_q;
        len_d       = len_q;
        mod_d       = mod_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        inflight_d  = issue;
        infl_last_d = issue && (rem_q == ADDR_W'(1));
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    trig_d  = bus.trig_addr;
                    pre_d   = bus.pretrig;
                    len_d   = bus.length;
                    mod_d   = bus.modulus;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                addr_d  = ADDR_W'(start_w);
                rem_d   = len_q;
                state_d = (len_q == '0) ? StDone : StRun;
            end
            StRun: begin
                if (issue) begin
                    rem_d  = rem_q - ADDR_W'(1);
                    addr_d = wrap_inc(addr_q, mod_q);
                end
                if (pop && head_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            trig_q      <= '0;
            pre_q       <= '0;
            len_q       <= '0;
            mod_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trig_d;
            pre_q       <= pre_d;
            len_q       <= len_d;
            mod_q       <= mod_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
        end
    end

    readout_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_last_i(infl_last_q),
        .push_data_i(bus.ram_rdata),
        .pop_i      (fifo_pop),
        .count_o    (fifo_cnt),
        .head_last_o(fifo_last),
        .head_data_o(fifo_data)
    );

    assign bus.busy      = (state_q == StLoad) || (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.ram_rd    = issue;
    assign bus.ram_addr  = addr_q;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = head_valid ? head_data : '0;
    assign bus.out_last  = head_valid && head_last;

endmodule

// File: doc/capture_readout.md
# capture_readout

Reads captured samples out of the scope's circular sample RAM, which the acquisition side writes with a 16-bit modulus address counter. On `start` it computes the window start address as the trigger address minus the pre-trigger depth, modulo the buffer depth (`modulus+1`). It then streams `length` samples in address order, wrapping from `modulus` to 0, onto a valid/ready output stream for the host/display interface. A small skid FIFO absorbs the 1-cycle RAM read latency under backpressure.

## Interface
- `ADDR_W`, 16: RAM address and length width.
- `DATA_W`, 8: sample width.
- `clk`  in  1: single clock; all logic on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request. Latches `trig_addr`, `pretrig`, `length` and `modulus`. Ignored while `busy`.
- `trig_addr`  in  ADDR_W: RAM address of the trigger sample.
- `pretrig`  in  ADDR_W: number of samples before the trigger. Clamped to `modulus`.
- `length`  in  ADDR_W: number of samples to emit. 0 means none.
- `modulus`  in  ADDR_W: highest valid RAM address. Buffer depth is `modulus+1`.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse when the readout completes.
- `ram_rd`  out  1: RAM read enable.
- `ram_addr`  out  ADDR_W: RAM read address.
- `ram_rdata`  in  DATA_W: RAM data. Valid exactly 1 cycle after `ram_rd`.
- `out_data`  out  DATA_W: sample.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: consumer accepts the sample.
- `out_last`  out  1: marks the final sample. Qualified by `out_valid`.

## Operation
- **FSM states:** IDLE, LOAD, RUN, DONE.
- **IDLE:**
  - `start` moves the FSM to LOAD and latches all inputs.
  - `busy` rises on the next edge.
- **LOAD, one cycle:**
  - `p = min(pretrig, modulus)`.
  - If `p <= trig_addr`: `addr = trig_addr - p`.
  - Else: `addr = trig_addr + modulus + 1 - p`.
  - Arithmetic is done in ADDR_W+1 bits.
  - `remaining = length`.
  - If `length == 0`, go to DONE. Otherwise go to RUN.
- **RUN:**
  - Issue `ram_rd` with `ram_addr = addr` when `remaining != 0` and `fifo_count + inflight - pop < 2`.
  - `pop = out_valid & out_ready`.
  - `inflight` is the read issued in the previous cycle.
  - On each issue:
    - `remaining` decrements.
    - `addr` becomes 0 if `addr == modulus`, otherwise `addr + 1`.
  - Returned data is pushed into the 2-entry FIFO.
  - The read that brings `remaining` to 0 is tagged last. The tag travels with its data to `out_last`.
  - Go to DONE in the cycle the tagged-last sample is popped.
- **DONE, one cycle:**
  - `done = 1`, `busy = 0`.
  - Return to IDLE.
  - A `start` arriving in DONE is ignored.
- **Ordering:** samples leave in exactly the issued address order. There is no loss and no duplication.
- **Output stability:** while `out_valid & !out_ready`, `out_data` and `out_last` hold stable.
- **`addr` range:** `addr` is never greater than `modulus`.

## Timing
- **Reset values:** `busy`, `done`, `ram_rd`, `out_valid` and `out_last` are 0. `ram_addr` and `out_data` are 0. The FIFO is empty and the FSM is in IDLE.
- **Reset mid-operation:** `reset_n` low at any point aborts immediately and asynchronously to the reset values. No `done` is produced. A RAM read still in flight is discarded.
- **Startup, `start` at cycle 0:** LOAD at cycle 1, first `ram_rd` at cycle 2, first `out_valid` at cycle 3.
- **Throughput:** with `out_ready` held high, one sample per cycle. The last sample appears at cycle `length+2` and `done` at cycle `length+3`.
- **Backpressure:** at most 2 samples are buffered or in flight combined. `ram_rd` stalls under backpressure and `ram_addr` holds during the stall.
- **`length == 0`:** LOAD at cycle 1, DONE pulse at cycle 2. No `ram_rd` and no `out_valid`.
- **Read data:** `ram_rdata` is sampled only on the cycle after `ram_rd`.

## Structure
- **Shared package `scope_pkg`:**
  - FSM state enum `rd_state_t`.
  - `ADDR_W` and `DATA_W` defaults.
  - Address-wrap increment function `wrap_inc(addr, modulus)`.
- **Sub-module `readout_skid`:**
  - 2-entry FIFO of `{last, data}`.
  - Ports: push, pop, count, head outputs.
  - Synchronous flush is not needed because reset covers it.

## Test plan
- **Plain window:** `modulus=1023`, `trig_addr=100`, `pretrig=10`, `length=4`, `out_ready=1` -> `ram_addr` reads 90, 91, 92, 93 on cycles 2–5. Data appears on cycles 3–6 with `out_last` on the 4th sample. `done` pulses at cycle 7.
- **Wrap:** `modulus=1023`, `trig_addr=5`, `pretrig=10`, `length=8` -> addresses 1019, 1020, 1021, 1022, 1023, 0, 1, 2.
- **Backpressure:** `length=64`, `out_ready` random at 30% -> output sequence equals the RAM contents at the issued addresses in order. Buffered plus in-flight never exceeds 2, and data/last are stable during stalls.
- **Zero length and clamp:**
  - `length=0` -> `done` at cycle 2 with no `ram_rd` and no `out_valid`.
  - `modulus=15`, `pretrig=40`, `trig_addr=3` -> start address 4, so p=15 is effectively a full-buffer window.
- **Start while busy:** a second `start` with different parameters during RUN -> it is ignored and the first readout completes unchanged.
- **Reset mid-run:** `reset_n` low mid-run -> all outputs 0 and no `done`. A following `start` produces a correct full readout.
